// File: rtl/input_event_feeder_if.sv
// Event bus between the host/sensor side and the monitor-facing feeder:
// the strobe plus value going in, and the x/newX pair going out.
interface input_event_feeder_if #(
   parameter int DATA_WIDTH = 64
);
   logic                         s_valid;
   logic signed [DATA_WIDTH-1:0] s_data;
   logic signed [DATA_WIDTH-1:0] x;
   logic                         newX;

   modport master (output s_valid, output s_data, input x, input newX);
   modport slave  (input s_valid, input s_data, output x, output newX);
endinterface

// File: rtl/input_event_feeder.sv
// Buffers non-stallable input events in a FIFO and replays each one to the
// monitor as a fixed-width newX pulse followed by a guaranteed idle gap.
module input_event_feeder #(
   parameter int DATA_WIDTH  = 64,
   parameter int DEPTH       = 8,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input_event_feeder_if.slave      ev,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     overflow,
   output logic [15:0]              drop_count
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_INIT  = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t                       state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic signed [DATA_WIDTH-1:0] x_q, x_d;
   logic                         newx_q, newx_d;
   logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]             level_q, level_d;
   logic                         ovf_q;
   logic [15:0]                  drop_q;
   logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic pop_req, pop, push, drop, full_w;

   assign full_w = (level_q == LVL_W'(DEPTH));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pop_req = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (level_q != '0) begin
               pop_req = 1'b1;
               state_d = HOLD;
               cnt_d   = HOLD_INIT;
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = GAP;
               cnt_d   = GAP_INIT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         GAP: begin
            // Back-to-back events skip IDLE so the steady-state period is HOLD+GAP.
            if (cnt_q == '0) begin
               if (level_q != '0) begin
                  pop_req = 1'b1;
                  state_d = HOLD;
                  cnt_d   = HOLD_INIT;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop    = en & pop_req;
      push   = en & ev.s_valid & (~full_w | pop);
      drop   = en & ev.s_valid & full_w & ~pop;
      newx_d = (state_d == HOLD);
      x_d    = pop ? mem_q[rd_ptr_q] : x_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         x_q      <= '0;
         newx_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else if (en) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         newx_q  <= newx_d;
         level_q <= level_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (drop) begin
            ovf_q  <= 1'b1;
            drop_q <= sat_inc(drop_q);
         end
      end
   end

   // Storage carries no reset; emptiness is defined by the pointers and level.
   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q] <= ev.s_data;
   end

   assign ev.x       = x_q;
   assign ev.newX    = newx_q;
   assign level      = level_q;
   assign full       = full_w;
   assign overflow   = ovf_q;
   assign drop_count = drop_q;
endmodule

// File: tb/tb_input_event_feeder.sv
// Directed bench for input_event_feeder: a per-cycle vector table for the
// basic scenarios plus hand-written overflow and drop-saturation sequences.
module tb_input_event_feeder;
   localparam int DW = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  level;
   logic        full;
   logic        overflow;
   logic [15:0] drop_count;

   input_event_feeder_if #(.DATA_WIDTH(DW)) ifc ();

   input_event_feeder #(
      .DATA_WIDTH(DW), .DEPTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .ev(ifc),
      .level(level), .full(full), .overflow(overflow), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r, e, v;
      logic [63:0] d;
      logic        nx;
      logic [63:0] x;
      logic [3:0]  lvl;
   } vec_t;

   vec_t tbl[$];
   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   task automatic row(input logic r, e, v, input logic [63:0] d,
                      input logic nx, input logic [63:0] x, input logic [3:0] lvl, input int n = 1);
      vec_t t;
      t.r = r; t.e = e; t.v = v; t.d = d; t.nx = nx; t.x = x; t.lvl = lvl;
      for (int i = 0; i < n; i++) tbl.push_back(t);
   endtask

   task automatic step(input logic r, e, v, input logic [63:0] d);
      rst = r; en = e; ifc.s_valid = v; ifc.s_data = d;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s (cycle %0d): got %0d, required %0d", name, cyc, act, exp);
      else
         passed++;
   endtask

   initial begin
      logic [63:0] q[$];
      int          lvl_m, drops_m, c, k;
      logic        pop_m, acc_m, prev, found, exp_nx;
      logic [63:0] exp_x;

      rst = 1'b1; en = 1'b1; ifc.s_valid = 1'b0; ifc.s_data = '0;

      // Single event, then burst of three, enable freeze, reset mid-HOLD.
      row(1,1,0,0, 0,0,0);
      row(0,1,1,1, 0,0,1);
      row(0,1,0,0, 1,1,0, 4);
      row(0,1,0,0, 0,1,0, 5);

      row(1,1,0,0, 0,0,0);
      row(0,1,1,5, 0,0,1);
      row(0,1,1,6, 1,5,1);
      row(0,1,1,7, 1,5,2);
      row(0,1,0,0, 1,5,2, 2);
      row(0,1,0,0, 0,5,2, 4);
      row(0,1,0,0, 1,6,1, 4);
      row(0,1,0,0, 0,6,1, 4);
      row(0,1,0,0, 1,7,0, 4);
      row(0,1,0,0, 0,7,0, 5);

      row(1,1,0,0, 0,0,0);
      row(0,1,1,3, 0,0,1);
      row(0,1,0,0, 1,3,0, 2);
      row(0,0,0,0, 1,3,0);
      row(0,0,1,99, 1,3,0);
      row(0,0,0,0, 1,3,0);
      row(0,1,0,0, 1,3,0, 2);
      row(0,1,0,0, 0,3,0, 5);

      row(1,1,0,0, 0,0,0);
      row(0,1,1,1, 0,0,1);
      row(0,1,1,2, 1,1,1);
      row(0,1,1,3, 1,1,2);
      row(0,1,0,0, 1,1,2);
      row(1,0,0,0, 0,0,0);
      row(0,1,1,9, 0,0,1);
      row(0,1,0,0, 1,9,0, 2);

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].d);
         total++;
         if (ifc.newX !== tbl[i].nx || ifc.x !== tbl[i].x || level !== tbl[i].lvl ||
             full !== 1'b0 || overflow !== 1'b0 || drop_count !== 16'd0)
            $display("FAIL row%0d: got newX=%0b x=%0d level=%0d full=%0b ovf=%0b drops=%0d, required newX=%0b x=%0d level=%0d full=0 ovf=0 drops=0",
                     i, ifc.newX, ifc.x, level, full, overflow, drop_count,
                     tbl[i].nx, tbl[i].x, tbl[i].lvl);
         else
            passed++;
      end

      // Overflow: 1..11 pushed on consecutive cycles, 11 dropped, 1..10 replayed.
      step(1,1,0,0);
      cyc = 0;
      for (int i = 0; i < 83; i++) begin
         step(0, 1, (i <= 10), 64'(i + 1));
         k      = (cyc - 2) / 8 + 1;
         exp_nx = (cyc >= 2) && (k <= 10) && (((cyc - 2) % 8) < 4);
         exp_x  = (cyc < 2) ? 64'd0 : ((k > 10) ? 64'd10 : 64'(k));
         chk("ovf_newX", 64'(ifc.newX), 64'(exp_nx));
         chk("ovf_x", ifc.x, exp_x);
         if (cyc == 9) begin
            chk("ovf_level_full", 64'(level), 64'd8);
            chk("ovf_full_flag", 64'(full), 64'd1);
         end
         if (cyc == 10) chk("ovf_not_yet", 64'(overflow), 64'd0);
         if (cyc == 11) begin
            chk("ovf_sticky", 64'(overflow), 64'd1);
            chk("ovf_drop1", 64'(drop_count), 64'd1);
            chk("ovf_level_held", 64'(level), 64'd8);
         end
      end
      chk("ovf_drained", 64'(level), 64'd0);
      chk("ovf_final_drops", 64'(drop_count), 64'd1);

      // Drop saturation: push every cycle until well past 0xFFFF drops.
      step(1,1,0,0);
      lvl_m = 0; drops_m = 0; c = 0;
      while (drops_m < 65540 && c < 80000) begin
         pop_m = ((c % 8) == 1) && (lvl_m > 0);
         acc_m = (lvl_m < 8) || pop_m;
         if (acc_m) q.push_back(64'(c + 1000)); else drops_m++;
         if (pop_m) void'(q.pop_front());
         lvl_m = lvl_m + int'(acc_m) - int'(pop_m);
         step(0, 1, 1, 64'(c + 1000));
         c++;
      end
      chk("sat_count", 64'(drop_count), 64'hFFFF);
      chk("sat_overflow", 64'(overflow), 64'd1);
      chk("sat_full", 64'(full), 64'd1);

      prev = ifc.newX;
      while (q.size() > 0) begin
         found = 1'b0;
         for (int w = 0; w < 24 && !found; w++) begin
            step(0,1,0,0);
            if (ifc.newX && !prev) found = 1'b1;
            prev = ifc.newX;
         end
         if (!found) begin
            chk("sat_drain_timeout", 64'd0, 64'd1);
            q.delete();
         end else begin
            chk("sat_drain_x", ifc.x, q.pop_front());
         end
      end
      for (int w = 0; w < 10; w++) step(0,1,0,0);
      chk("sat_empty", 64'(level), 64'd0);
      chk("sat_count_held", 64'(drop_count), 64'hFFFF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
